// File: rtl/doa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : doa_pkg
//  Description : Shared constants, FSM state encoding and the microphone
//                pair lookup for the TDOA pair scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package doa_pkg;

   localparam int          NUM_MICS     = 6;
   localparam int          NUM_PAIRS    = 15;
   localparam int          TDOA_W       = 16;
   localparam int          PAIR_IDX_W   = 4;
   // Stored in place of a TDOA when the engine never answers (most negative value)
   localparam logic [15:0] TDOA_TIMEOUT = 16'h8000;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REQ      = 3'd1,
      WAIT     = 3'd2,
      KICK     = 3'd3,
      WAIT_DOA = 3'd4
   } state_e;

   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
   } mic_pair_t;

   // Pair k -> (lower mic, higher mic), enumerating i<j row by row
   function automatic mic_pair_t pair_lut(input logic [PAIR_IDX_W-1:0] k);
      mic_pair_t p;
      case (k)
         4'd0:    p = {3'd0, 3'd1};
         4'd1:    p = {3'd0, 3'd2};
         4'd2:    p = {3'd0, 3'd3};
         4'd3:    p = {3'd0, 3'd4};
         4'd4:    p = {3'd0, 3'd5};
         4'd5:    p = {3'd1, 3'd2};
         4'd6:    p = {3'd1, 3'd3};
         4'd7:    p = {3'd1, 3'd4};
         4'd8:    p = {3'd1, 3'd5};
         4'd9:    p = {3'd2, 3'd3};
         4'd10:   p = {3'd2, 3'd4};
         4'd11:   p = {3'd2, 3'd5};
         4'd12:   p = {3'd3, 3'd4};
         4'd13:   p = {3'd3, 3'd5};
         default: p = {3'd4, 3'd5};
      endcase
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tdoa_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tdoa_bank
//  Description : One TDOA register per microphone pair, single write port,
//                all entries visible on a flat output bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdoa_bank #(
   parameter int NUM_PAIRS = doa_pkg::NUM_PAIRS,
   parameter int TDOA_W    = doa_pkg::TDOA_W,
   parameter int IDX_W     = doa_pkg::PAIR_IDX_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          we_i,
   input  logic [IDX_W-1:0]              idx_i,
   input  logic [TDOA_W-1:0]             data_i,
   output logic [NUM_PAIRS*TDOA_W-1:0]   flat_o
);

   for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_entry
      logic [TDOA_W-1:0] entry_q;

      // Entry holds its value until its own index is written
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            entry_q <= '0;
         end else if (we_i && (idx_i == IDX_W'(k))) begin
            entry_q <= data_i;
         end
      end

      assign flat_o[k*TDOA_W +: TDOA_W] = entry_q;
   end

endmodule
`default_nettype wire

// File: rtl/tdoa_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tdoa_pair_scheduler
//  Description : Walks all microphone pairs through a shared cross-correlation
//                engine, banks the TDOA results (sentinel on timeout) and then
//                launches the DOA stage once per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdoa_pair_scheduler #(
   parameter int NUM_PAIRS = doa_pkg::NUM_PAIRS,
   parameter int TDOA_W    = doa_pkg::TDOA_W,
   parameter int TIMEOUT   = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          frame_valid,
   output logic                          xc_req,
   output logic [2:0]                    xc_mic_a,
   output logic [2:0]                    xc_mic_b,
   input  logic                          xc_ack,
   input  logic                          xc_done,
   input  logic [TDOA_W-1:0]             xc_tdoa,
   output logic [NUM_PAIRS*TDOA_W-1:0]   tdoas_flat,
   output logic                          doa_start,
   input  logic                          doa_done,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          timeout_err,
   output logic                          overrun
);

   import doa_pkg::*;

   localparam int                    CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [PAIR_IDX_W-1:0] LAST_PAIR = PAIR_IDX_W'(NUM_PAIRS - 1);
   localparam logic [TDOA_W-1:0]     SENTINEL  = TDOA_W'(TDOA_TIMEOUT);

   state_e                 state_q;
   logic [PAIR_IDX_W-1:0]  pair_idx_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   xc_req_q;
   logic [2:0]             mic_a_q;
   logic [2:0]             mic_b_q;
   logic                   doa_start_q;
   logic                   busy_q;
   logic                   frame_done_q;
   logic                   timeout_err_q;
   logic                   overrun_q;

   logic                   result_take;
   logic                   expired;
   logic                   bank_we;
   logic [TDOA_W-1:0]      bank_data;
   mic_pair_t              first_pair;
   mic_pair_t              next_pair;

   // A real result always beats an expiring counter in the same cycle
   assign result_take = (state_q == WAIT) && xc_done;
   assign expired     = (state_q == WAIT) && !xc_done && (cnt_q == CNT_LAST);
   assign bank_we     = result_take || expired;
   assign bank_data   = xc_done ? xc_tdoa : SENTINEL;
   assign first_pair  = pair_lut('0);
   assign next_pair   = pair_lut(pair_idx_q + PAIR_IDX_W'(1));

   // Frame sequencer: request, await result or timeout, advance, then kick DOA
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pair_idx_q    <= '0;
         cnt_q         <= '0;
         xc_req_q      <= 1'b0;
         mic_a_q       <= 3'd0;
         mic_b_q       <= 3'd0;
         doa_start_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         doa_start_q  <= 1'b0;
         frame_done_q <= 1'b0;
         // Any frame_valid outside IDLE is dropped, including the doa_done cycle
         overrun_q    <= frame_valid && (state_q != IDLE);

         case (state_q)
            IDLE: begin
               if (frame_valid) begin
                  state_q            <= REQ;
                  pair_idx_q         <= '0;
                  cnt_q              <= '0;
                  timeout_err_q      <= 1'b0;
                  xc_req_q           <= 1'b1;
                  {mic_a_q, mic_b_q} <= first_pair;
                  busy_q             <= 1'b1;
               end
            end
            REQ: begin
               if (xc_ack) begin
                  state_q  <= WAIT;
                  xc_req_q <= 1'b0;
                  cnt_q    <= '0;
               end
            end
            WAIT: begin
               if (bank_we) begin
                  if (expired) begin
                     timeout_err_q <= 1'b1;
                  end
                  if (pair_idx_q == LAST_PAIR) begin
                     state_q     <= KICK;
                     doa_start_q <= 1'b1;
                  end else begin
                     state_q            <= REQ;
                     pair_idx_q         <= pair_idx_q + PAIR_IDX_W'(1);
                     xc_req_q           <= 1'b1;
                     {mic_a_q, mic_b_q} <= next_pair;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            KICK: begin
               state_q <= WAIT_DOA;
            end
            WAIT_DOA: begin
               if (doa_done) begin
                  state_q      <= IDLE;
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q  <= IDLE;
               xc_req_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   tdoa_bank #(
      .NUM_PAIRS (NUM_PAIRS),
      .TDOA_W    (TDOA_W),
      .IDX_W     (PAIR_IDX_W)
   ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (bank_we),
      .idx_i  (pair_idx_q),
      .data_i (bank_data),
      .flat_o (tdoas_flat)
   );

   assign xc_req      = xc_req_q;
   assign xc_mic_a    = mic_a_q;
   assign xc_mic_b    = mic_b_q;
   assign doa_start   = doa_start_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;
   assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_tdoa_pair_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdoa_pair_scheduler
//  Description : Self-checking bench for tdoa_pair_scheduler with a behavioural
//                cross-correlation engine / DOA responder and a pair-bank model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdoa_pair_scheduler;

   localparam int NP = 15;
   localparam int TW = 16;
   localparam int TO = 1024;
   localparam int BUDGET = 5000;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            frame_valid = 1'b0;
   logic            xc_ack = 1'b0;
   logic            xc_done = 1'b0;
   logic            doa_done = 1'b0;
   logic [TW-1:0]   xc_tdoa = '0;
   logic            xc_req, doa_start, busy, frame_done, timeout_err, overrun;
   logic [2:0]      xc_mic_a, xc_mic_b;
   logic [NP*TW-1:0] tdoas_flat;

   int checks = 0;
   int failures = 0;

   // Stimulus configuration for one frame
   int          cfg_ack[NP];
   int          cfg_done[NP];
   logic [15:0] cfg_tdoa[NP];
   int          cfg_ovr_pair, cfg_doa_dly, cfg_rst_pair;
   bit          cfg_ovr_doa, cfg_spur;

   // Observations of one frame
   int          obs_n, obs_unstable, obs_doa_start, obs_frame_done, obs_overrun;
   int          obs_lat, obs_busy_low, obs_req_after;
   bit          obs_hang, obs_aborted;
   logic [2:0]  obs_a[16];
   logic [2:0]  obs_b[16];
   logic [11:0] obs_rst_vec;
   logic [NP*TW-1:0] obs_rst_bank;

   // Reference model
   logic [2:0]  exp_a[NP];
   logic [2:0]  exp_b[NP];
   logic [15:0] exp_bank[NP];
   bit          exp_err;

   tdoa_pair_scheduler #(.NUM_PAIRS(NP), .TDOA_W(TW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
      .xc_req(xc_req), .xc_mic_a(xc_mic_a), .xc_mic_b(xc_mic_b),
      .xc_ack(xc_ack), .xc_done(xc_done), .xc_tdoa(xc_tdoa),
      .tdoas_flat(tdoas_flat), .doa_start(doa_start), .doa_done(doa_done),
      .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic build_pairs();
      int k = 0;
      for (int i = 0; i < 6; i++)
         for (int j = i + 1; j < 6; j++) begin
            exp_a[k] = 3'(i);
            exp_b[k] = 3'(j);
            k++;
         end
   endtask

   task automatic init_cfg();
      for (int k = 0; k < NP; k++) begin
         cfg_ack[k]  = 1;
         cfg_done[k] = 1;
         cfg_tdoa[k] = 16'($urandom_range(1, 65535));
      end
      cfg_ovr_pair = -1; cfg_ovr_doa = 0; cfg_doa_dly = 1;
      cfg_rst_pair = -1; cfg_spur = 0;
   endtask

   // Engine that never answers, or answers after the TIMEOUT-th wait cycle, yields the sentinel
   task automatic model_frame();
      exp_err = 0;
      for (int k = 0; k < NP; k++) begin
         if (cfg_done[k] < 1 || cfg_done[k] > TO) begin
            exp_bank[k] = 16'h8000;
            exp_err = 1;
         end else begin
            exp_bank[k] = cfg_tdoa[k];
         end
      end
   endtask

   function automatic logic [NP*TW-1:0] exp_flat();
      logic [NP*TW-1:0] v;
      for (int k = 0; k < NP; k++) v[k*TW +: TW] = exp_bank[k];
      return v;
   endfunction

   // Drives one frame and plays engine / DOA stage; records what the DUT did
   task automatic drive_frame();
      int  mode = 0, rcnt = 0, wcnt = 0, dcnt = 0, post = 0, n = 0, it = 0;
      bit  ack_sent = 0, done_sent = 0, doa_seen = 0, fd_seen = 0;
      obs_n = 0; obs_unstable = 0; obs_doa_start = 0; obs_frame_done = 0;
      obs_overrun = 0; obs_lat = 0; obs_busy_low = 0; obs_req_after = 0;
      obs_hang = 0; obs_aborted = 0;
      for (int k = 0; k < 16; k++) begin obs_a[k] = 'x; obs_b[k] = 'x; end
      @(negedge clk);
      frame_valid = 1'b1;
      forever begin
         @(negedge clk);
         it++;
         frame_valid = 1'b0; xc_ack = 1'b0; xc_done = 1'b0; doa_done = 1'b0;
         if (it > BUDGET || obs_n >= 16) begin obs_hang = 1; break; end
         if (doa_start) begin
            obs_doa_start++;
            if (!doa_seen) obs_lat = it;
            doa_seen = 1; dcnt = 0;
         end else if (doa_seen) dcnt++;
         if (overrun) obs_overrun++;
         if (frame_done) obs_frame_done++;
         if (fd_seen) begin
            post++;
            if (xc_req) obs_req_after++;
            if (post >= 4) break;
         end else if (frame_done) fd_seen = 1;
         else if (!busy) obs_busy_low++;

         if (ack_sent) begin ack_sent = 0; mode = 1; wcnt = 0; end
         if (done_sent) begin done_sent = 0; mode = 0; rcnt = 0; n++; end
         if (mode == 1 && (xc_req || doa_start)) begin mode = 0; rcnt = 0; n++; end

         if (mode == 0 && xc_req) begin
            rcnt++;
            if (rcnt == 1) begin
               obs_a[obs_n] = xc_mic_a; obs_b[obs_n] = xc_mic_b; obs_n++;
               if (n == cfg_ovr_pair) frame_valid = 1'b1;
            end else if (xc_mic_a !== obs_a[obs_n-1] || xc_mic_b !== obs_b[obs_n-1]) begin
               obs_unstable++;
            end
            if (n < NP && rcnt == cfg_ack[n]) begin
               xc_ack = 1'b1; ack_sent = 1;
            end else if (cfg_spur) begin
               xc_done = 1'b1; xc_tdoa = 16'($urandom);
            end
         end else if (mode == 1) begin
            wcnt++;
            if (n == cfg_rst_pair && wcnt == 1) begin
               #2 rst_n = 1'b0;
               #1 obs_rst_vec = {xc_req, xc_mic_a, xc_mic_b, doa_start, busy,
                                 frame_done, timeout_err, overrun};
               obs_rst_bank = tdoas_flat;
               repeat (3) begin
                  @(negedge clk);
                  if (doa_start) obs_doa_start++;
                  if (frame_done) obs_frame_done++;
               end
               rst_n = 1'b1;
               obs_aborted = 1;
               break;
            end
            if (n < NP && wcnt == cfg_done[n]) begin
               xc_done = 1'b1; xc_tdoa = cfg_tdoa[n]; done_sent = 1;
            end else if (cfg_spur) begin
               xc_ack = 1'b1;
            end
         end
         if (doa_seen && !fd_seen && dcnt == cfg_doa_dly) begin
            doa_done = 1'b1;
            if (cfg_ovr_doa) frame_valid = 1'b1;
         end
      end
      frame_valid = 1'b0; xc_ack = 1'b0; xc_done = 1'b0; doa_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({xc_req, xc_mic_a, xc_mic_b, doa_start, busy, frame_done, timeout_err, overrun} !== 12'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 000",
                  {xc_req, xc_mic_a, xc_mic_b, doa_start, busy, frame_done, timeout_err, overrun});
      end
      checks++;
      if (tdoas_flat !== '0) begin
         failures++; $display("FAIL reset_bank: got %h expected 0", tdoas_flat);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || xc_req !== 1'b0) begin
         failures++; $display("FAIL idle_after_reset: busy=%b xc_req=%b expected 0 0", busy, xc_req);
      end
   endtask

   task automatic test_single_frame();
      init_cfg();
      for (int k = 0; k < NP; k++) begin
         cfg_tdoa[k] = 16'(k + 1); cfg_ack[k] = 2; cfg_done[k] = 2;
      end
      model_frame();
      drive_frame();
      checks++;
      if (obs_hang !== 1'b0) begin failures++; $display("FAIL single_hang: frame did not complete"); end
      checks++;
      if (obs_n !== NP) begin failures++; $display("FAIL single_pair_count: got %0d expected %0d", obs_n, NP); end
      for (int k = 0; k < NP; k++) begin
         checks++;
         if ({obs_a[k], obs_b[k]} !== {exp_a[k], exp_b[k]}) begin
            failures++;
            $display("FAIL single_pair_seq[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                     k, obs_a[k], obs_b[k], exp_a[k], exp_b[k]);
         end
      end
      checks++;
      if (tdoas_flat !== exp_flat()) begin
         failures++; $display("FAIL single_bank: got %h expected %h", tdoas_flat, exp_flat());
      end
      checks++;
      if (obs_doa_start !== 1 || obs_frame_done !== 1 || obs_overrun !== 0) begin
         failures++;
         $display("FAIL single_pulses: doa_start=%0d frame_done=%0d overrun=%0d expected 1 1 0",
                  obs_doa_start, obs_frame_done, obs_overrun);
      end
      checks++;
      if (obs_lat < 1 + NP * 3) begin
         failures++; $display("FAIL single_latency: got %0d expected >= %0d", obs_lat, 1 + NP * 3);
      end
      checks++;
      if (obs_busy_low !== 0 || timeout_err !== 1'b0) begin
         failures++; $display("FAIL single_busy_err: busy_low=%0d err=%b expected 0 0", obs_busy_low, timeout_err);
      end
   endtask

   task automatic test_random_frames();
      repeat (3) begin
         init_cfg();
         for (int k = 0; k < NP; k++) begin
            cfg_ack[k]  = int'($urandom_range(1, 5));
            cfg_done[k] = int'($urandom_range(1, 5));
         end
         cfg_doa_dly = int'($urandom_range(1, 6));
         cfg_spur = 1;
         model_frame();
         drive_frame();
         checks++;
         if (obs_hang !== 1'b0 || obs_n !== NP) begin
            failures++; $display("FAIL rand_progress: hang=%b pairs=%0d expected 0 %0d", obs_hang, obs_n, NP);
         end
         for (int k = 0; k < NP; k++) begin
            checks++;
            if ({obs_a[k], obs_b[k]} !== {exp_a[k], exp_b[k]}) begin
               failures++;
               $display("FAIL rand_pair_seq[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                        k, obs_a[k], obs_b[k], exp_a[k], exp_b[k]);
            end
         end
         checks++;
         if (tdoas_flat !== exp_flat()) begin
            failures++; $display("FAIL rand_bank: got %h expected %h", tdoas_flat, exp_flat());
         end
         checks++;
         if (obs_doa_start !== 1 || obs_frame_done !== 1 || obs_overrun !== 0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL rand_pulses: doa_start=%0d frame_done=%0d overrun=%0d err=%b expected 1 1 0 0",
                     obs_doa_start, obs_frame_done, obs_overrun, timeout_err);
         end
      end
   endtask

   task automatic test_timeout();
      logic [NP*TW-1:0] held;
      init_cfg();
      cfg_done[7] = -1;
      model_frame();
      drive_frame();
      checks++;
      if (obs_hang !== 1'b0 || obs_n !== NP) begin
         failures++; $display("FAIL timeout_progress: hang=%b pairs=%0d expected 0 %0d", obs_hang, obs_n, NP);
      end
      checks++;
      if (tdoas_flat[7*TW +: TW] !== 16'h8000) begin
         failures++; $display("FAIL timeout_entry7: got %h expected 8000", tdoas_flat[7*TW +: TW]);
      end
      checks++;
      if (tdoas_flat !== exp_flat()) begin
         failures++; $display("FAIL timeout_bank: got %h expected %h", tdoas_flat, exp_flat());
      end
      checks++;
      if (timeout_err !== exp_err || obs_doa_start !== 1 || obs_frame_done !== 1) begin
         failures++;
         $display("FAIL timeout_flags: err=%b doa_start=%0d frame_done=%0d expected %b 1 1",
                  timeout_err, obs_doa_start, obs_frame_done, exp_err);
      end
      held = tdoas_flat;
      repeat (20) @(negedge clk);
      checks++;
      if (tdoas_flat !== exp_flat() || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL idle_hold: bank %h err=%b expected %h 1", tdoas_flat, timeout_err, held);
      end
   endtask

   task automatic test_tie();
      init_cfg();
      cfg_tdoa[0] = 16'h0010;
      cfg_done[0] = TO;
      model_frame();
      drive_frame();
      checks++;
      if (tdoas_flat[0 +: TW] !== 16'h0010) begin
         failures++; $display("FAIL tie_entry0: got %h expected 0010", tdoas_flat[0 +: TW]);
      end
      checks++;
      if (timeout_err !== 1'b0 || obs_hang !== 1'b0) begin
         failures++; $display("FAIL tie_err: err=%b hang=%b expected 0 0", timeout_err, obs_hang);
      end
   endtask

   task automatic test_ack_stall();
      init_cfg();
      cfg_ack[0]  = 51;
      cfg_done[0] = TO - 10;
      model_frame();
      drive_frame();
      checks++;
      if (obs_unstable !== 0) begin
         failures++; $display("FAIL stall_stable: got %0d changes expected 0", obs_unstable);
      end
      checks++;
      if (timeout_err !== 1'b0 || tdoas_flat !== exp_flat()) begin
         failures++; $display("FAIL stall_result: err=%b bank %h expected 0 %h", timeout_err, tdoas_flat, exp_flat());
      end
   endtask

   task automatic test_overrun();
      init_cfg();
      cfg_ovr_pair = 3;
      model_frame();
      drive_frame();
      checks++;
      if (obs_overrun !== 1) begin
         failures++; $display("FAIL ovr_pulse: got %0d expected 1", obs_overrun);
      end
      checks++;
      if (obs_n !== NP || obs_doa_start !== 1 || obs_frame_done !== 1 || tdoas_flat !== exp_flat()) begin
         failures++;
         $display("FAIL ovr_frame: pairs=%0d doa_start=%0d frame_done=%0d bank %h expected %0d 1 1 %h",
                  obs_n, obs_doa_start, obs_frame_done, tdoas_flat, NP, exp_flat());
      end
   endtask

   task automatic test_overrun_doa();
      init_cfg();
      cfg_ovr_doa = 1;
      cfg_doa_dly = 3;
      model_frame();
      drive_frame();
      checks++;
      if (obs_overrun !== 1 || obs_frame_done !== 1) begin
         failures++; $display("FAIL ovr_doa_pulse: overrun=%0d frame_done=%0d expected 1 1", obs_overrun, obs_frame_done);
      end
      checks++;
      if (obs_req_after !== 0 || busy !== 1'b0) begin
         failures++; $display("FAIL ovr_doa_ignored: req_after=%0d busy=%b expected 0 0", obs_req_after, busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      init_cfg();
      cfg_rst_pair = 5;
      drive_frame();
      checks++;
      if (obs_aborted !== 1'b1) begin
         failures++; $display("FAIL rst_reached: got %b expected 1", obs_aborted);
      end
      checks++;
      if (obs_rst_vec !== 12'd0 || obs_rst_bank !== '0) begin
         failures++; $display("FAIL rst_async: ctrl %h bank %h expected 000 0", obs_rst_vec, obs_rst_bank);
      end
      checks++;
      if (obs_doa_start !== 0 || obs_frame_done !== 0) begin
         failures++; $display("FAIL rst_abort: doa_start=%0d frame_done=%0d expected 0 0", obs_doa_start, obs_frame_done);
      end
      init_cfg();
      model_frame();
      drive_frame();
      checks++;
      if (obs_a[0] !== 3'd0 || obs_b[0] !== 3'd1) begin
         failures++; $display("FAIL rst_restart: got (%0d,%0d) expected (0,1)", obs_a[0], obs_b[0]);
      end
      checks++;
      if (obs_n !== NP || tdoas_flat !== exp_flat() || obs_frame_done !== 1) begin
         failures++;
         $display("FAIL rst_new_frame: pairs=%0d frame_done=%0d bank %h expected %0d 1 %h",
                  obs_n, obs_frame_done, tdoas_flat, NP, exp_flat());
      end
   endtask

   initial begin
      build_pairs();
      test_reset();
      test_single_frame();
      test_random_frames();
      test_timeout();
      test_tie();
      test_ack_stall();
      test_overrun();
      test_overrun_doa();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tdoa_pair_scheduler.md
TDOA_PAIR_SCHEDULER -- requirements
Module: tdoa_pair_scheduler

Interface
REQ-001 Parameter NUM_PAIRS, default 15, is the number of microphone pairs for 6 mics, i<j.
REQ-002 Parameter TDOA_W, default 16, is the TDOA word width in bits.
REQ-003 Parameter TIMEOUT, default 1024, is the maximum number of cycles to wait for xc_done per pair.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle pulse: a new 6-mic frame is captured.
- xc_req  out  1  request to the shared cross-correlation engine.
- xc_mic_a  out  3  lower mic index of the current pair.
- xc_mic_b  out  3  higher mic index of the current pair.
- xc_ack  in  1  engine accepted the request.
- xc_done  in  1  engine result valid, one-cycle pulse.
- xc_tdoa  in  TDOA_W  signed TDOA result, sampled when xc_done=1.
- tdoas_flat  out  NUM_PAIRS*TDOA_W  TDOA bank; pair k occupies bits [k*TDOA_W +: TDOA_W].
- doa_start  out  1  one-cycle pulse that launches the DOA stage.
- doa_done  in  1  DOA stage finished, pulse.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- timeout_err  out  1  sticky; set when any pair times out.
- overrun  out  1  one-cycle pulse when frame_valid is dropped.

Function
REQ-005 Pair order k=0..14 SHALL be (0,1),(0,2),(0,3),(0,4),(0,5),(1,2),(1,3),(1,4),(1,5),(2,3),(2,4),(2,5),(3,4),(3,5),(4,5), taken from a constant lookup.
REQ-006 FSM states SHALL be IDLE, REQ, WAIT, KICK, WAIT_DOA.
REQ-007 IDLE: frame_valid=1 SHALL set pair_idx=0 and go to REQ on the next edge.
REQ-008 REQ: xc_req=1 with xc_mic_a/b=pair(pair_idx), held stable until xc_ack=1; xc_ack SHALL move the FSM to WAIT and clear the timeout counter.
REQ-009 WAIT: xc_req=0; on xc_done=1, bank[pair_idx] SHALL load xc_tdoa.
REQ-010 After that load: if pair_idx=NUM_PAIRS-1, go to KICK; otherwise increment pair_idx and go to REQ.
REQ-011 WAIT timeout: when the counter reaches TIMEOUT-1 with no xc_done, bank[pair_idx] SHALL load 16'h8000 (sentinel) and timeout_err SHALL set; sequencing then continues exactly as in REQ-010.
REQ-012 xc_done and timeout in the same cycle: xc_done SHALL win (real value stored, no error).
REQ-013 KICK: doa_start=1 for exactly one cycle, then go to WAIT_DOA.
REQ-014 WAIT_DOA: on doa_done=1, frame_done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-015 frame_valid while busy=1 SHALL be ignored and SHALL pulse overrun for one cycle.
REQ-016 frame_valid coinciding with the doa_done cycle SHALL also count as overrun.
REQ-017 tdoas_flat SHALL hold its values between frames and update only per REQ-009 or REQ-011.
REQ-018 xc_ack while not in REQ, and xc_done while not in WAIT, SHALL be ignored.
REQ-019 Latency floor: frame_valid to doa_start SHALL be at least 1+15*3 cycles when xc_ack and xc_done each respond one cycle after being awaited.
REQ-020 timeout_err SHALL clear only on reset or on the frame_valid that starts a new frame.

Reset
REQ-021 rst_n=0 SHALL asynchronously force:
- FSM to IDLE, pair_idx=0, timeout counter=0;
- tdoas_flat=0, timeout_err=0;
- all other outputs to 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame with no doa_start and no frame_done.

Structure
REQ-023 Package doa_pkg SHALL hold NUM_MICS, NUM_PAIRS, TDOA_W, the TDOA_TIMEOUT sentinel 16'h8000, the FSM state enum, and the pair lookup table.
REQ-024 One sub-module, tdoa_bank, SHALL implement the 15-entry register file: write enable, index, data in, flat output.

Verification
REQ-025 Single frame, ack/done after 1 cycle each, xc_tdoa=k+1 for pair k -> mic pairs follow REQ-005; tdoas_flat entry k=k+1; one doa_start; after doa_done, one frame_done.
REQ-026 Pair 7 never returns xc_done -> after 1024 WAIT cycles, entry 7=16'h8000 and timeout_err=1; pairs 8..14 still processed; doa_start still issued.
REQ-027 frame_valid during pair 3 -> overrun pulses once; the frame completes normally; exactly one frame_done.
REQ-028 rst_n low during WAIT of pair 5 -> all outputs 0 immediately (asynchronously); no doa_start; a new frame_valid restarts at pair (0,1).
REQ-029 xc_done and timeout in the same cycle on pair 0, xc_tdoa=16'h0010 -> entry 0=16'h0010, timeout_err=0.
REQ-030 xc_ack held low for 50 cycles in REQ -> xc_req, xc_mic_a and xc_mic_b stay stable; no timeout counted.
